vicuna_cluster_ctrl: RTL and testbench



---
 rtl/vicuna_cluster_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_vicuna_cluster_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vicuna_cluster_ctrl.sv
// Run-control unit for a cluster of NumCores vicuna cores: reset sequencing, boot address, run cycles, done irq.
// Define VICUNA_CLUSTER_WATCHDOG_EN to add the per-core run-cycle watchdog (WDOG_TIMEOUT / WDOG_ERR).
//
// state   | meaning
// --------+---------------------------------------------------------------
// HALTED  | core held in reset, idle; BOOT_ADDR writable
// ARMING  | core held in reset for ResetHoldCycles cycles before release
// RUNNING | core out of reset, CYCLES counting (saturating)
// DONE    | core signalled done, back in reset, CYCLES frozen
module vicuna_cluster_ctrl #(
  parameter int unsigned NumCores        = 2,
  parameter logic [31:0] BootAddrDefault = 32'h0,
  parameter int unsigned ResetHoldCycles = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_req_i,
  input  logic                   reg_we_i,
  input  logic [7:0]             reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  output logic [31:0]            reg_rdata_o,
  output logic                   reg_rvalid_o,
  output logic                   reg_err_o,
  input  logic [NumCores-1:0]    core_done_i,
  output logic [NumCores-1:0]    core_rst_no,
  output logic [NumCores*32-1:0] boot_addr_o,
  output logic                   irq_o
);

  typedef enum logic [1:0] {
    HALTED  = 2'd0,
    ARMING  = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } core_state_e;

  localparam logic [7:0] HoldInit = 8'(ResetHoldCycles - 1);

  core_state_e         state_q  [NumCores];
  core_state_e         state_d  [NumCores];
  logic [7:0]          hold_q   [NumCores];
  logic [7:0]          hold_d   [NumCores];
  logic [31:0]         cycles_q [NumCores];
  logic [31:0]         cycles_d [NumCores];
  logic [31:0]         boot_q   [NumCores];
  logic [31:0]         boot_d   [NumCores];
  logic [NumCores-1:0] status_q, status_d, irq_en_q, irq_en_d;
  logic [NumCores-1:0] start_req, halt_req, status_clr, done_set, running;
  logic [5:0]          word;
  logic                wr, rd, hit, err_d;
  logic [31:0]         rdata_d, cyc_inc;
  logic                unused_addr;

`ifdef VICUNA_CLUSTER_WATCHDOG_EN
  logic [31:0]         wdog_timeout_q, wdog_timeout_d;
  logic [NumCores-1:0] wdog_err_q, wdog_err_d, wdog_set, wdog_clr;
`endif

  assign word        = reg_addr_i[7:2];
  assign wr          = reg_req_i & reg_we_i;
  assign rd          = reg_req_i & ~reg_we_i;
  assign unused_addr = ^reg_addr_i[1:0];

  // Write decode; BOOT_ADDR only accepts writes while its core is in reset and idle.
  always_comb begin
    start_req  = '0;
    halt_req   = '0;
    status_clr = '0;
    irq_en_d   = irq_en_q;
`ifdef VICUNA_CLUSTER_WATCHDOG_EN
    wdog_timeout_d = wdog_timeout_q;
    wdog_clr       = '0;
`endif
    if (wr) begin
      case (word)
        6'd0:    start_req  = reg_wdata_i[NumCores-1:0];
        6'd1:    halt_req   = reg_wdata_i[NumCores-1:0];
        6'd2:    status_clr = reg_wdata_i[NumCores-1:0];
        6'd3:    irq_en_d   = reg_wdata_i[NumCores-1:0];
`ifdef VICUNA_CLUSTER_WATCHDOG_EN
        6'd60:   wdog_timeout_d = reg_wdata_i;
        6'd61:   wdog_clr       = reg_wdata_i[NumCores-1:0];
`endif
        default: ;
      endcase
    end
    for (int n = 0; n < NumCores; n++) begin
      boot_d[n] = boot_q[n];
      if (wr && word == 6'(4 + 2 * n) &&
          (state_q[n] == HALTED || state_q[n] == DONE)) begin
        boot_d[n] = reg_wdata_i;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    hit     = 1'b0;
    case (word)
      6'd0:    begin hit = 1'b1; rdata_d[NumCores-1:0] = running;  end
      6'd1:    hit = 1'b1;
      6'd2:    begin hit = 1'b1; rdata_d[NumCores-1:0] = status_q; end
      6'd3:    begin hit = 1'b1; rdata_d[NumCores-1:0] = irq_en_q; end
`ifdef VICUNA_CLUSTER_WATCHDOG_EN
      6'd60:   begin hit = 1'b1; rdata_d = wdog_timeout_q;           end
      6'd61:   begin hit = 1'b1; rdata_d[NumCores-1:0] = wdog_err_q; end
`endif
      default: ;
    endcase
    for (int n = 0; n < NumCores; n++) begin
      if (word == 6'(4 + 2 * n)) begin
        hit     = 1'b1;
        rdata_d = boot_q[n];
      end
      if (word == 6'(5 + 2 * n)) begin
        hit     = 1'b1;
        rdata_d = cycles_q[n];
      end
    end
    err_d = ~hit;
    if (!rd) rdata_d = '0;
  end

  // Per-core next state; halt beats done, done beats the watchdog.
  always_comb begin
    done_set = '0;
    cyc_inc  = '0;
`ifdef VICUNA_CLUSTER_WATCHDOG_EN
    wdog_set = '0;
`endif
    for (int n = 0; n < NumCores; n++) begin
      state_d[n]  = state_q[n];
      hold_d[n]   = hold_q[n];
      cycles_d[n] = cycles_q[n];
      cyc_inc     = (cycles_q[n] == 32'hFFFF_FFFF) ? cycles_q[n] : cycles_q[n] + 32'd1;
      case (state_q[n])
        HALTED: begin
          if (start_req[n] && !halt_req[n]) begin
            state_d[n]  = ARMING;
            hold_d[n]   = HoldInit;
            cycles_d[n] = '0;
          end
        end
        ARMING: begin
          if (halt_req[n])           state_d[n] = HALTED;
          else if (hold_q[n] == '0)  state_d[n] = RUNNING;
          else                       hold_d[n]  = hold_q[n] - 8'd1;
        end
        RUNNING: begin
          cycles_d[n] = cyc_inc;
          if (halt_req[n]) begin
            state_d[n] = HALTED;
          end else if (core_done_i[n]) begin
            state_d[n]  = DONE;
            done_set[n] = 1'b1;
          end
`ifdef VICUNA_CLUSTER_WATCHDOG_EN
          else if (wdog_timeout_q != '0 && cyc_inc == wdog_timeout_q) begin
            state_d[n]  = HALTED;
            wdog_set[n] = 1'b1;
          end
`endif
        end
        DONE: begin
          if (halt_req[n]) begin
            state_d[n] = HALTED;
          end else if (start_req[n]) begin
            state_d[n]  = ARMING;
            hold_d[n]   = HoldInit;
            cycles_d[n] = '0;
          end
        end
        default: state_d[n] = HALTED;
      endcase
    end
    status_d = (status_q & ~status_clr) | done_set;
`ifdef VICUNA_CLUSTER_WATCHDOG_EN
    wdog_err_d = (wdog_err_q & ~wdog_clr) | wdog_set;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NumCores; n++) begin
        state_q[n]  <= HALTED;
        hold_q[n]   <= '0;
        cycles_q[n] <= '0;
        boot_q[n]   <= BootAddrDefault;
      end
      status_q     <= '0;
      irq_en_q     <= '0;
      reg_rdata_o  <= '0;
      reg_rvalid_o <= 1'b0;
      reg_err_o    <= 1'b0;
`ifdef VICUNA_CLUSTER_WATCHDOG_EN
      wdog_timeout_q <= '0;
      wdog_err_q     <= '0;
`endif
    end else begin
      for (int n = 0; n < NumCores; n++) begin
        state_q[n]  <= state_d[n];
        hold_q[n]   <= hold_d[n];
        cycles_q[n] <= cycles_d[n];
        boot_q[n]   <= boot_d[n];
      end
      status_q     <= status_d;
      irq_en_q     <= irq_en_d;
      reg_rdata_o  <= rdata_d;
      reg_rvalid_o <= reg_req_i;
      reg_err_o    <= reg_req_i & err_d;
`ifdef VICUNA_CLUSTER_WATCHDOG_EN
      wdog_timeout_q <= wdog_timeout_d;
      wdog_err_q     <= wdog_err_d;
`endif
    end
  end

  always_comb begin
    boot_addr_o = '0;
    for (int n = 0; n < NumCores; n++) begin
      running[n]              = (state_q[n] == RUNNING);
      boot_addr_o[32*n +: 32] = boot_q[n];
    end
  end

  assign core_rst_no = running;

`ifdef VICUNA_CLUSTER_WATCHDOG_EN
  assign irq_o = |((status_q | wdog_err_q) & irq_en_q);
`else
  assign irq_o = |(status_q & irq_en_q);
`endif

endmodule

// File: tb/tb_vicuna_cluster_ctrl.sv
// Directed bench for vicuna_cluster_ctrl (NumCores=2, ResetHoldCycles=4): register vector table plus sequences.
module tb_vicuna_cluster_ctrl;

  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we;
  logic [7:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          rvalid, rerr;
  logic [NC-1:0] done;
  logic [NC-1:0] core_rst_n;
  logic [NC*32-1:0] boot;
  logic          irq;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vicuna_cluster_ctrl #(
    .NumCores(NC), .BootAddrDefault(32'h0), .ResetHoldCycles(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
    .reg_rdata_o(rdata), .reg_rvalid_o(rvalid), .reg_err_o(rerr),
    .core_done_i(done), .core_rst_no(core_rst_n), .boot_addr_o(boot), .irq_o(irq)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One register access; returns just after the edge that accepted it.
  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd_o, output logic err_o);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    check("rvalid", {31'b0, rvalid}, 32'h1);
    rd_o  = rdata;
    err_o = rerr;
    req   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic        e;
    bus(1'b1, a, d, r, e);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    bus(1'b0, a, 32'h0, r, e);
    check(name, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,          32'h0,          1'b0};
    vecs[1]  = '{1'b0, 8'h10, 32'h0,          32'h0,          1'b0};
    vecs[2]  = '{1'b1, 8'h0C, 32'hFFFF_FFFF,  32'h0,          1'b0};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,          32'h3,          1'b0};
    vecs[4]  = '{1'b1, 8'h14, 32'h0000_1234,  32'h0,          1'b0};
    vecs[5]  = '{1'b0, 8'h14, 32'h0,          32'h0,          1'b0};
    vecs[6]  = '{1'b0, 8'h80, 32'h0,          32'h0,          1'b1};
    vecs[7]  = '{1'b1, 8'h80, 32'hFFFF_FFFF,  32'h0,          1'b1};
    vecs[8]  = '{1'b0, 8'h0C, 32'h0,          32'h3,          1'b0};
    vecs[9]  = '{1'b1, 8'h18, 32'h0001_0000,  32'h0,          1'b0};
    vecs[10] = '{1'b0, 8'h1B, 32'h0,          32'h0001_0000,  1'b0};
    vecs[11] = '{1'b0, 8'h04, 32'h0,          32'h0,          1'b0};
    vecs[12] = '{1'b0, 8'h08, 32'h0,          32'h0,          1'b0};
    vecs[13] = '{1'b1, 8'h0C, 32'h0,          32'h0,          1'b0};
    vecs[14] = '{1'b0, 8'h0C, 32'h0,          32'h0,          1'b0};
    vecs[15] = '{1'b0, 8'h20, 32'h0,          32'h0,          1'b1};
    vecs[16] = '{1'b0, 8'hFC, 32'h0,          32'h0,          1'b1};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; done = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_rst_no", {30'b0, core_rst_n}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_boot0", boot[31:0], 32'h0);
    check("rst_boot1", boot[63:32], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, r, e);
      check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
    end
    @(posedge clk);
    #1;
    check("idle_rvalid", {31'b0, rvalid}, 32'h0);
    check("boot1_out", boot[63:32], 32'h0001_0000);

    // core 1 release timing
    wr(8'h00, 32'h2);
    check("arm_t0", {31'b0, core_rst_n[1]}, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("arm_t%0d", k), {31'b0, core_rst_n[1]}, 32'h0);
    end
    @(posedge clk);
    #1;
    check("release_t4", {31'b0, core_rst_n[1]}, 32'h1);
    rd_chk("ctrl_running", 8'h00, 32'h2);
    wr(8'h18, 32'hDEAD_BEEF);
    rd_chk("boot1_frozen", 8'h18, 32'h0001_0000);
    check("boot1_out_frozen", boot[63:32], 32'h0001_0000);

    // core 0 runs 100 cycles then signals done
    wr(8'h0C, 32'h1);
    wr(8'h00, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("core0_released", {31'b0, core_rst_n[0]}, 32'h1);
    repeat (99) @(posedge clk);
    @(negedge clk); done = 2'b01;
    @(posedge clk); #1; done = 2'b00;
    check("done_rst", {31'b0, core_rst_n[0]}, 32'h0);
    check("done_irq", {31'b0, irq}, 32'h1);
    rd_chk("status_done", 8'h08, 32'h1);
    rd_chk("cycles0_100", 8'h14, 32'd100);
    rd_chk("ctrl_after_done", 8'h00, 32'h2);
    wr(8'h08, 32'h1);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    @(negedge clk); done = 2'b01;
    @(posedge clk); #1; done = 2'b00;
    rd_chk("done_ignored", 8'h08, 32'h0);
    rd_chk("cycles0_frozen", 8'h14, 32'd100);

    // restart from DONE; W1C and new done on the same edge
    wr(8'h00, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("core0_rerun", {31'b0, core_rst_n[0]}, 32'h1);
    rd_chk("cycles0_cleared", 8'h14, 32'h0);
    done = 2'b01;
    wr(8'h08, 32'h1);
    done = 2'b00;
    rd_chk("w1c_vs_set", 8'h08, 32'h1);
    wr(8'h08, 32'h1);

    // boot write while running ignored; halt beats done
    wr(8'h00, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("core0_run3", {31'b0, core_rst_n[0]}, 32'h1);
    wr(8'h10, 32'h0000_5555);
    rd_chk("boot0_frozen", 8'h10, 32'h0);
    done = 2'b01;
    wr(8'h04, 32'h1);
    done = 2'b00;
    check("halt_rst", {31'b0, core_rst_n[0]}, 32'h0);
    rd_chk("halt_wins", 8'h08, 32'h0);
    rd_chk("ctrl_after_halt", 8'h00, 32'h2);
    wr(8'h10, 32'h00AB_C000);
    rd_chk("boot0_halted_wr", 8'h10, 32'h00AB_C000);
    check("boot0_out", boot[31:0], 32'h00AB_C000);

    // halt core 1 while running, then during arming
    wr(8'h04, 32'h2);
    check("halt1_rst", {30'b0, core_rst_n}, 32'h0);
    rd_chk("ctrl_none", 8'h00, 32'h0);
    wr(8'h00, 32'h2);
    wr(8'h04, 32'h2);
    repeat (6) @(posedge clk);
    #1;
    check("halt_in_arming", {31'b0, core_rst_n[1]}, 32'h0);

`ifdef VICUNA_CLUSTER_WATCHDOG_EN
    wr(8'hF0, 32'd50);
    wr(8'h0C, 32'h2);
    wr(8'h00, 32'h2);
    repeat (4) @(posedge clk);
    repeat (49) @(posedge clk);
    #1;
    check("wdog_pre", {31'b0, core_rst_n[1]}, 32'h1);
    @(posedge clk);
    #1;
    check("wdog_fire", {31'b0, core_rst_n[1]}, 32'h0);
    rd_chk("wdog_err", 8'hF4, 32'h2);
    check("wdog_irq", {31'b0, irq}, 32'h1);
    rd_chk("wdog_cycles", 8'h1C, 32'd50);
    wr(8'hF4, 32'h2);
    check("wdog_irq_clr", {31'b0, irq}, 32'h0);
`else
    bus(1'b0, 8'hF0, 32'h0, r, e);
    check("wdog_unmapped", {31'b0, e}, 32'h1);
`endif

    // asynchronous reset mid-run
    wr(8'h00, 32'h2);
    repeat (5) @(posedge clk);
    #1;
    check("pre_async", {31'b0, core_rst_n[1]}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {30'b0, core_rst_n}, 32'h0);
    check("async_boot0", boot[31:0], 32'h0);
    check("async_boot1", boot[63:32], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_chk("post_rst_irq_en", 8'h0C, 32'h0);
    rd_chk("post_rst_ctrl", 8'h00, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
